iomem_dbg_master: RTL and testbench
===================================

// Module: iomem_dbg_master
// PURPOSE
//  Byte-stream-to-iomem bus initiator: the master end of the iomem valid/ready bus served by the board-level GPIO/MMIO responders.
//  Parses read/write commands from a byte source (UART RX), issues one iomem transaction per command, returns result bytes to a byte sink (UART TX).
//  Lets the host poke and peek 0x03/0x06/0x07 peripherals without firmware. Sits beside the core, muxed onto the iomem bus.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles iomem_valid is held awaiting iomem_ready; 0 = wait forever
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  rx_data      in   8   command byte
//  rx_valid     in   1   rx_data valid
//  rx_ready     out  1   byte accepted when rx_valid&rx_ready
//  tx_data      out  8   response byte
//  tx_valid     out  1   tx_data valid; held with data stable until tx_ready
//  tx_ready     in   1   sink accepts byte
//  iomem_valid  out  1   transaction request
//  iomem_ready  in   1   responder completion (one-cycle pulse)
//  iomem_wstrb  out  4   byte strobes; 0 = read
//  iomem_addr   out  32  address
//  iomem_wdata  out  32  write data
//  iomem_rdata  in   32  read data, valid when iomem_ready=1
//  busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (rx_ready=0 during reset, 1 in IDLE after); state IDLE; byte counter 0.
//  Commands (multi-byte fields LSB first): 'W'(0x57) A0..A3 D0..D3 ; 'R'(0x52) A0..A3.
//  Responses: write ok 'K'(0x4B); read ok 'D'(0x44) R0..R3; timeout 'E'(0x45); unknown cmd '?'(0x3F).
//  States: IDLE -> ADDR(4 bytes) -> [DATA(4 bytes), writes only] -> BUS -> RESP -> IDLE.
//   IDLE: unknown byte -> RESP with '?'; no bus cycle.
//  rx_ready=1 only in IDLE/ADDR/DATA; 0 in BUS/RESP (no byte lost, source stalls).
//  BUS: iomem_valid=1 from first BUS cycle; addr/wdata/wstrb stable while valid.
//   Cycle iomem_ready=1 sampled: capture rdata, iomem_valid=0 on next edge, -> RESP. Min latency last cmd byte -> valid: 1 clk.
//   iomem_ready while valid=0 ignored.
//   Timeout counter increments each BUS cycle; on reaching TIMEOUT_CYCLES with no ready: valid=0, -> RESP with 'E'.
//   Ready and timeout on same cycle: ready wins.
//  RESP: bytes emitted in order; advance on tx_valid&tx_ready; after last byte tx_valid=0, -> IDLE. Back-to-back commands allowed with no gap.
//  wstrb: 4'hF for 'W', 4'h0 for 'R' (see CONFIGURATION).
//  Reset mid-operation: aborts at next edge; iomem_valid and tx_valid drop, partial command discarded, no response.
// CONFIGURATION
//  IOMEM_DBG_WSTRB_EN defined: 'W' carries extra byte S after D3; iomem_wstrb=S[3:0]; S[3:0]=0 -> no bus cycle, respond 'E'.
//  Undefined: no S byte, wstrb fixed 4'hF.
// STRUCTURE
//  Package iomem_dbg_pkg: state enum, command/response byte constants (CMD_WR, CMD_RD, RSP_OK, RSP_DATA, RSP_ERR, RSP_BAD).
//  One sub-module natural: iomem_dbg_txser (4-byte+header response serializer, valid/ready); parser and bus FSM stay in top.
// TESTING
//  57 00 00 00 03 A5 00 00 00, responder ready after 2 clk -> addr=0x03000000, wdata=0x000000A5, wstrb=F, then tx 4B.
//  52 00 00 00 06, responder rdata=0x00000005 -> wstrb=0, tx 44 05 00 00 00.
//  52 00 00 00 09 (no responder), TIMEOUT_CYCLES=16 -> valid held exactly 16 clk, then tx 45.
//  Byte 0x13 in IDLE -> tx 3F, iomem_valid never asserted.
//  tx_ready low 10 clk during read reply -> tx_data/tx_valid stable, rx_ready=0 throughout; reset pulse in BUS -> valid=0 next clk, no tx.
//  With IOMEM_DBG_WSTRB_EN: 57 00 00 00 03 44 33 22 11 02 -> wstrb=4'b0010; S=00 -> tx 45, no bus cycle.

Source files
------------

// File: rtl/iomem_dbg_pkg.sv
// Shared types and byte constants for the iomem debug master.
// IOMEM_DBG_WSTRB_EN adds a strobe byte after the write data.
package iomem_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_DATA = 8'h44;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned TMO_W = 32;

`ifdef IOMEM_DBG_WSTRB_EN
  localparam int unsigned DATA_BYTES = 5;
`else
  localparam int unsigned DATA_BYTES = 4;
`endif

endpackage

// File: rtl/iomem_dbg_txser.sv
// Response serializer: header byte plus up to four data bytes, LSB first,
// on a valid/ready byte stream. Loaded by a one-cycle pulse.
module iomem_dbg_txser
  import iomem_dbg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [7:0]       i_hdr,
  input  logic [31:0]      i_data,
  input  logic [LEN_W-1:0] i_len,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_done_c
);

  logic [39:0]      r_sh;
  logic [LEN_W-1:0] r_left;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh    <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sh    <= {i_data, i_hdr};
      r_left  <= i_len;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      // Hold the last byte on the bus after it drains; only valid drops.
      if (r_left == LEN_W'(1)) begin
        r_valid <= 1'b0;
      end else begin
        r_sh   <= {8'h00, r_sh[39:8]};
        r_left <= r_left - LEN_W'(1);
      end
    end
  end

  assign o_tx_data  = r_sh[7:0];
  assign o_tx_valid = r_valid;
  assign o_done_c   = r_valid && i_tx_ready && (r_left == LEN_W'(1));

endmodule

// File: rtl/iomem_dbg_master.sv
// Byte-stream to iomem bus initiator: parses 'W'/'R' commands, runs one bus
// cycle each, and returns a response. IOMEM_DBG_WSTRB_EN enables the strobe byte.
module iomem_dbg_master
  import iomem_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  logic [TMO_W-1:0] r_tmo;
  logic [31:0]      r_rdata;
  logic             r_rx_ready;
  logic             r_busy;
  logic             r_valid;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_load;
  logic [7:0]       r_hdr;
  logic [LEN_W-1:0] r_len;

  logic w_rx_fire;
  logic w_tx_done;

  assign w_rx_fire = rx_valid && r_rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_tmo      <= '0;
      r_rdata    <= '0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_wstrb    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_load     <= 1'b0;
      r_hdr      <= '0;
      r_len      <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              r_is_wr <= (rx_data == CMD_WR);
              r_state <= S_ADDR;
            end else begin
              r_rx_ready <= 1'b0;
              r_state    <= S_RESP;
              r_load     <= 1'b1;
              r_hdr      <= RSP_BAD;
              r_len      <= LEN_W'(1);
            end
          end
        end

        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {rx_data, r_addr[31:8]};
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(3)) begin
              r_cnt <= '0;
              if (r_is_wr) begin
                r_state <= S_DATA;
              end else begin
                r_rx_ready <= 1'b0;
                r_valid    <= 1'b1;
                r_wstrb    <= 4'h0;
                r_state    <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (w_rx_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt < CNT_W'(4)) begin
              r_wdata <= {rx_data, r_wdata[31:8]};
            end
            if (r_cnt == CNT_W'(DATA_BYTES - 1)) begin
              r_cnt      <= '0;
              r_rx_ready <= 1'b0;
`ifdef IOMEM_DBG_WSTRB_EN
              // A zero strobe is rejected without touching the bus.
              if (rx_data[3:0] == 4'h0) begin
                r_state <= S_RESP;
                r_load  <= 1'b1;
                r_hdr   <= RSP_ERR;
                r_len   <= LEN_W'(1);
              end else begin
                r_valid <= 1'b1;
                r_wstrb <= rx_data[3:0];
                r_state <= S_BUS;
              end
`else
              r_valid <= 1'b1;
              r_wstrb <= 4'hF;
              r_state <= S_BUS;
`endif
            end
          end
        end

        S_BUS: begin
          // Completion takes priority over a timeout in the same cycle.
          if (iomem_ready) begin
            r_rdata <= iomem_rdata;
            r_valid <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_RESP;
            r_load  <= 1'b1;
            r_hdr   <= r_is_wr ? RSP_OK : RSP_DATA;
            r_len   <= r_is_wr ? LEN_W'(1) : LEN_W'(5);
          end else if (TIMEOUT_CYCLES != 0 && r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_valid <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_RESP;
            r_load  <= 1'b1;
            r_hdr   <= RSP_ERR;
            r_len   <= LEN_W'(1);
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_RESP: begin
          if (w_tx_done) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  iomem_dbg_txser u_txser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_load),
    .i_hdr      (r_hdr),
    .i_data     (r_rdata),
    .i_len      (r_len),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done_c   (w_tx_done)
  );

  assign rx_ready    = r_rx_ready;
  assign busy        = r_busy;
  assign iomem_valid = r_valid;
  assign iomem_wstrb = r_wstrb;
  assign iomem_addr  = r_addr;
  assign iomem_wdata = r_wdata;

endmodule

// File: tb/tb_iomem_dbg_master.sv
// Scoreboard bench for iomem_dbg_master: a driver pushes expected bus cycles and
// reply bytes; a responder and a tx monitor pop and compare. Honors IOMEM_DBG_WSTRB_EN.
module tb_iomem_dbg_master;

  localparam int TMO = 16;
  localparam logic [7:0] C_WR   = 8'h57;
  localparam logic [7:0] C_RD   = 8'h52;
  localparam logic [7:0] R_OK   = 8'h4B;
  localparam logic [7:0] R_DATA = 8'h44;
  localparam logic [7:0] R_ERR  = 8'h45;
  localparam logic [7:0] R_BAD  = 8'h3F;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
  } bus_t;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit tx_block = 1'b0;
  bit abort    = 1'b0;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];

  iomem_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Caller is always positioned 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) fail("rx_stuck");
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Reference model: derives bus cycle and reply purely from the command rules.
  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int lat, input logic [31:0] rdata);
    bus_t t;
    bit   go;
    bit   is_wr;
    is_wr = (op == C_WR);
    if (!is_wr && op != C_RD) begin
      exp_tx.push_back(R_BAD);
      send_byte(op);
      return;
    end
    go      = 1'b1;
    t.addr  = addr;
    t.wdata = wdata;
    t.lat   = lat;
    t.rdata = rdata;
    t.wstrb = is_wr ? 4'hF : 4'h0;
`ifdef IOMEM_DBG_WSTRB_EN
    if (is_wr) begin
      t.wstrb = strb;
      go      = (strb != 4'h0);
    end
`endif
    if (go) exp_bus.push_back(t);
    if (!go || lat >= TMO) exp_tx.push_back(R_ERR);
    else if (is_wr) exp_tx.push_back(R_OK);
    else begin
      exp_tx.push_back(R_DATA);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (is_wr) begin
      for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
`ifdef IOMEM_DBG_WSTRB_EN
      send_byte({4'($urandom), strb});
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail("drain_timeout");
  endtask

  // Read that never completes, cut short by a reset pulse while on the bus.
  task automatic do_abort();
    bus_t t;
    t.addr  = 32'h0700_0020;
    t.wdata = 32'h0;
    t.wstrb = 4'h0;
    t.lat   = 100000;
    t.rdata = 32'h0;
    exp_bus.push_back(t);
    send_byte(C_RD);
    for (int i = 0; i < 4; i++) send_byte(t.addr[8*i +: 8]);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_valid", 32'(iomem_valid), 32'd1);
    abort = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(iomem_valid), 32'd0);
    check("abort_txv", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_tx", 32'(tx_valid), 32'd0);
    check("abort_idle_rdy", 32'(rx_ready), 32'd1);
  endtask

  // Bus responder: verifies each request and completes it after its latency.
  initial begin : responder
    bus_t cur;
    int   cyc;
    bit   act;
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    cyc = 0;
    act = 1'b0;
    cur.addr = 32'h0; cur.wdata = 32'h0; cur.wstrb = 4'h0; cur.lat = 0; cur.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      iomem_ready = 1'b0;
      if (iomem_valid) begin
        if (!act) begin
          if (exp_bus.size() == 0) begin
            fail("bus_unexpected");
            cur.lat = 100000;
          end else begin
            cur = exp_bus.pop_front();
          end
          act = 1'b1;
          cyc = 0;
        end
        check("bus_addr", iomem_addr, cur.addr);
        check("bus_wstrb", 32'(iomem_wstrb), 32'(cur.wstrb));
        if (cur.wstrb != 4'h0) check("bus_wdata", iomem_wdata, cur.wdata);
        if (cyc == cur.lat) begin
          iomem_ready = 1'b1;
          iomem_rdata = cur.rdata;
        end
        cyc++;
      end else begin
        if (act) begin
          if (abort) abort = 1'b0;
          else check("bus_valid_len", 32'(cyc), 32'((cur.lat < TMO) ? cur.lat + 1 : TMO));
          act = 1'b0;
        end
        // Stray completion pulses with no request pending must be ignored.
        if ($urandom_range(0, 7) == 0) begin
          iomem_ready = 1'b1;
          iomem_rdata = $urandom;
        end
      end
    end
  end

  // Reply monitor: pops expected bytes on each accepted transfer.
  initial begin : tx_mon
    logic [7:0] prev_d;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev_d     = 8'h0;
    tx_ready   = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_d));
      end
      if (tx_valid) check("rx_rdy_in_resp", 32'(rx_ready), 32'd0);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) fail("tx_unexpected");
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        prev_stall = 1'b0;
      end else begin
        prev_stall = tx_valid;
        prev_d     = tx_data;
      end
      @(posedge clk); #1;
      tx_ready = tx_block ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #900000;
    fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int          n;
    int          sel;
    int          lat;
    int          kind;
    logic [7:0]  op;
    logic [31:0] a;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_addr", iomem_addr, 32'd0);
    check("rst_wdata", iomem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    do_cmd(C_WR, 32'h0300_0000, 32'h0000_00A5, 4'hF, 2, 32'h0);
    do_cmd(C_RD, 32'h0600_0000, 32'h0, 4'h0, 1, 32'h0000_0005);
    do_cmd(C_RD, 32'h0900_0000, 32'h0, 4'h0, 1000, 32'h0);
    do_cmd(8'h13, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    do_cmd(C_RD, 32'h0700_0004, 32'h0, 4'h0, TMO - 1, 32'hCAFE_F00D);
`ifdef IOMEM_DBG_WSTRB_EN
    do_cmd(C_WR, 32'h0300_0000, 32'h1122_3344, 4'b0010, 1, 32'h0);
    do_cmd(C_WR, 32'h0300_0000, 32'h1122_3344, 4'h0, 1, 32'h0);
`endif
    drain();

    tx_block = 1'b1;
    do_cmd(C_RD, 32'h0700_0010, 32'h0, 4'h0, 3, 32'hDEAD_BEEF);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_valid) fail("stall_no_tx");
    repeat (10) @(posedge clk);
    #1;
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    check("stall_tx_data", 32'(tx_data), 32'(R_DATA));
    check("stall_rx_ready", 32'(rx_ready), 32'd0);
    tx_block = 1'b0;
    drain();

    do_abort();

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 10);
      sel  = $urandom_range(0, 9);
      if (sel < 6) lat = $urandom_range(0, 4);
      else if (sel == 6) lat = TMO - 1;
      else if (sel == 7) lat = TMO + $urandom_range(0, 20);
      else lat = $urandom_range(5, 14);
      case ($urandom_range(0, 2))
        0: a = {8'h03, 24'($urandom)};
        1: a = {8'h06, 24'($urandom)};
        default: a = {8'h07, 24'($urandom)};
      endcase
      if (kind < 5) op = C_WR;
      else if (kind < 10) op = C_RD;
      else begin
        op = 8'($urandom);
        if (op == C_WR || op == C_RD) op = 8'h00;
      end
      do_cmd(op, a, $urandom, 4'($urandom), lat, $urandom);
    end
    drain();

    check("end_busy", 32'(busy), 32'd0);
    check("end_iomem_valid", 32'(iomem_valid), 32'd0);
    check("end_bus_queue", 32'(exp_bus.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
